// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin arbiter that serialises one requester's code/data into an 8-byte TX FIFO frame.
// Optional TX_FRAME_CSUM_EN: byte 6 carries the XOR of code and the four data bytes instead of 0x00.
module tx_frame_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TX_FIFO_LOAD_W = 13,
  parameter int TX_FIFO_DEPTH  = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [8*N_REQ-1:0]        req_code,
  input  logic [32*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]          ack,
  input  logic [TX_FIFO_LOAD_W-1:0] txfifo_load,
  input  logic                      txfifo_full,
  output logic                      txfifo_wr,
  output logic [7:0]                txfifo_data,
  output logic                      busy
);
  localparam int RW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_d;
  logic [RW-1:0] rr, g, k;
  logic [2:0] idx;
  logic [7:0] code_q, csum;
  logic [7:0] frame [8];
  logic [31:0] data_q;
  logic space, grant;
  assign space = txfifo_load <= TX_FIFO_LOAD_W'(TX_FIFO_DEPTH - 8);
  assign grant = rst_n && state == IDLE && |req && space;
  // Scan from the highest offset down so the requester closest to rr wins.
  always_comb begin
    g = rr;
    k = rr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = RW'((int'(rr) + i) % N_REQ);
      if (req[k]) g = k;
    end
  end
`ifdef TX_FRAME_CSUM_EN
  assign csum = code_q ^ data_q[7:0] ^ data_q[15:8] ^ data_q[23:16] ^ data_q[31:24];
`else
  assign csum = 8'h00;
`endif
  assign frame = '{8'h55, data_q[7:0], data_q[15:8], data_q[23:16], data_q[31:24], code_q, csum, 8'hAA};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = grant ? SEND : (state == SEND && !txfifo_full && idx == 3'd7) ? IDLE : state;
  always_comb begin
    busy = state == SEND;
    txfifo_wr = busy && !txfifo_full;
    txfifo_data = busy ? frame[idx] : 8'h00;
    ack = grant ? N_REQ'(1) << g : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr <= '0;
      idx <= '0;
      code_q <= '0;
      data_q <= '0;
    end else if (grant) begin
      rr <= (g == RW'(N_REQ - 1)) ? '0 : g + 1'b1;
      idx <= '0;
      code_q <= req_code[8*int'(g) +: 8];
      data_q <= req_data[32*int'(g) +: 32];
    end else if (txfifo_wr) begin
      idx <= idx + 3'd1;
    end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: queue-based frame model checked every cycle, plus directed literal checks.
module tb_tx_frame_arbiter;
  localparam int DEPTH = 4096;
  logic clk = 0, rst_n = 0, txfifo_full = 0, txfifo_wr, busy;
  logic [3:0] req = 0, ack;
  logic [31:0] req_code = 0;
  logic [127:0] req_data = 0;
  logic [12:0] txfifo_load = 0;
  logic [7:0] txfifo_data;
  int checks = 0, errors = 0;
  logic [7:0] wlog[$];
  int alog[$];
  logic m_busy = 0;
  int m_rr = 0, m_g;
  logic [7:0] mq[$];
  logic [3:0] e_ack;
  logic e_wr, e_busy;
  logic [7:0] e_data, m_code, m_cs;
  logic [31:0] m_d;

  tx_frame_arbiter dut (.clk(clk), .rst_n(rst_n), .req(req), .req_code(req_code), .req_data(req_data),
    .ack(ack), .txfifo_load(txfifo_load), .txfifo_full(txfifo_full), .txfifo_wr(txfifo_wr),
    .txfifo_data(txfifo_data), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: a pending frame is just a queue of bytes still to be written.
  always @(negedge clk) begin
    e_ack = 0;
    e_wr = 0;
    e_data = 0;
    e_busy = 0;
    if (!rst_n) begin
      m_busy = 0;
      m_rr = 0;
      mq.delete();
    end else begin
      e_busy = m_busy;
      e_wr = m_busy && !txfifo_full;
      e_data = m_busy ? mq[0] : 8'h00;
      if (!m_busy && req != 0 && int'(txfifo_load) <= DEPTH - 8) begin
        m_g = -1;
        for (int i = 0; i < 4; i++)
          if (m_g < 0 && req[(m_rr + i) % 4]) m_g = (m_rr + i) % 4;
        e_ack[m_g] = 1'b1;
        m_code = req_code[8*m_g +: 8];
        m_d = req_data[32*m_g +: 32];
`ifdef TX_FRAME_CSUM_EN
        m_cs = m_code ^ m_d[7:0] ^ m_d[15:8] ^ m_d[23:16] ^ m_d[31:24];
`else
        m_cs = 8'h00;
`endif
        mq.push_back(8'h55); mq.push_back(m_d[7:0]); mq.push_back(m_d[15:8]); mq.push_back(m_d[23:16]);
        mq.push_back(m_d[31:24]); mq.push_back(m_code); mq.push_back(m_cs); mq.push_back(8'hAA);
        m_rr = (m_g + 1) % 4;
        m_busy = 1;
      end else if (m_busy && !txfifo_full) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_busy = 0;
      end
    end
    chk("ack", 32'(ack), 32'(e_ack));
    chk("wr", 32'(txfifo_wr), 32'(e_wr));
    chk("data", 32'(txfifo_data), 32'(e_data));
    chk("busy", 32'(busy), 32'(e_busy));
    if (txfifo_wr) wlog.push_back(txfifo_data);
    for (int i = 0; i < 4; i++) if (ack[i]) alog.push_back(i);
  end

  initial begin
    logic [7:0] exp2 [8];
    logic [7:0] exp4 [8];
    int a3 [5];
    a3 = '{0, 1, 2, 3, 0};
`ifdef TX_FRAME_CSUM_EN
    exp2 = '{8'h55, 8'h23, 8'h01, 8'h01, 8'h00, 8'h01, 8'h22, 8'hAA};
    exp4 = '{8'h55, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC3, 8'hE1, 8'hAA};
`else
    exp2 = '{8'h55, 8'h23, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'hAA};
    exp4 = '{8'h55, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hC3, 8'h00, 8'hAA};
`endif
    // 1: reset with a request held
    req = 4'b0001;
    #1;
    step(3);
    chk("rst_wr", 32'(txfifo_wr), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    req = 0;
    rst_n = 1;
    step(2);
    // 2: single frame from requester 1
    wlog.delete(); alog.delete();
    req_code[15:8] = 8'h01;
    req_data[63:32] = 32'h00010123;
    req = 4'b0010;
    step(1);
    req = 0;
    step(10);
    chk("t2_nbytes", wlog.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_byte", 32'(wlog[i]), 32'(exp2[i]));
    chk("t2_nack", alog.size(), 1);
    chk("t2_grant", alog[0], 1);
    chk("t2_busy", 32'(busy), 0);
    // 3: all requesting, rr restarted at 0
    rst_n = 0;
    step(1);
    rst_n = 1;
    wlog.delete(); alog.delete();
    req = 4'b1111;
    step(37);
    req = 0;
    step(10);
    chk("t3_nack", alog.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_order", alog[i], a3[i]);
    chk("t3_nbytes", wlog.size(), 40);
    // 4: stall for 3 cycles after byte 2
    wlog.delete(); alog.delete();
    req_code[7:0] = 8'hC3;
    req_data[31:0] = 32'hDEADBEEF;
    req = 4'b0001;
    step(1);
    req = 0;
    step(3);
    txfifo_full = 1;
    step(3);
    txfifo_full = 0;
    step(10);
    chk("t4_nbytes", wlog.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4_byte", 32'(wlog[i]), 32'(exp4[i]));
    // 5: not enough FIFO space, then exactly enough
    wlog.delete(); alog.delete();
    txfifo_load = 13'(DEPTH - 7);
    req = 4'b0001;
    step(4);
    chk("t5_noack", alog.size(), 0);
    chk("t5_nowr", wlog.size(), 0);
    txfifo_load = 13'(DEPTH - 8);
    step(1);
    chk("t5_ack", alog.size(), 1);
    req = 0;
    txfifo_load = 0;
    step(10);
    chk("t5_nbytes", wlog.size(), 8);
    // 6: reset mid-frame after byte 4, pending request restarts from byte 0
    wlog.delete(); alog.delete();
    req_code[7:0] = 8'h5A;
    req_data[31:0] = 32'h11223344;
    req = 4'b0001;
    step(1);
    req = 0;
    step(5);
    chk("t6_partial", wlog.size(), 5);
    rst_n = 0;
    req = 4'b0001;
    #1;
    chk("t6_wr_drop", 32'(txfifo_wr), 0);
    chk("t6_busy_drop", 32'(busy), 0);
    chk("t6_data_zero", 32'(txfifo_data), 0);
    wlog.delete();
    step(2);
    rst_n = 1;
    step(1);
    req = 0;
    step(10);
    chk("t6_nbytes", wlog.size(), 8);
    chk("t6_first", 32'(wlog[0]), 32'h55);
    chk("t6_code", 32'(wlog[5]), 32'h5A);
    chk("t6_last", 32'(wlog[7]), 32'hAA);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
